// File: rtl/strobe_pkg.sv
// strobe_pkg: monitor FSM state type and the period/tolerance range checks shared by the strobe monitor files
package strobe_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} strobe_mon_state_t;
  function automatic logic div_ok(input int div);
    return div >= 2;
  endfunction
  function automatic logic tol_ok(input int div, input int tol);
    return tol >= 0 && tol <= div - 1;
  endfunction
  function automatic logic lock_ok(input int lock_count);
    return lock_count >= 1;
  endfunction
  function automatic logic is_early(input int interval, input int div, input int tol);
    return interval < div - tol;
  endfunction
  function automatic logic in_window(input int interval, input int div, input int tol);
    return interval >= div - tol && interval <= div + tol;
  endfunction
endpackage

// File: rtl/strobe_interval_timer.sv
// strobe_interval_timer: saturating cycles-since-strobe counter, interval on a strobe cycle, one-shot timeout
module strobe_interval_timer
  import strobe_pkg::*;
#(
  parameter int DIV = 10,
  parameter int TOL = 1,
  parameter int CW  = $clog2(DIV + TOL + 2)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_strobe,
  output logic [CW-1:0] o_interval,
  output logic          o_timeout,
  output logic          o_timed_out
);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV + TOL);
  logic [CW-1:0] cnt;
  assign o_interval = cnt + CW'(1);
  assign o_timeout  = (cnt == CNT_MAX) && !o_timed_out;
  // count cycles since the last strobe, stick at the limit, and remember a timeout until the next strobe
  always_ff @(posedge i_clk)
    if (i_reset) begin
      cnt         <= '0;
      o_timed_out <= 1'b0;
    end else begin
      cnt         <= i_strobe ? '0 : (cnt == CNT_MAX ? cnt : cnt + CW'(1));
      o_timed_out <= !i_strobe && (o_timed_out || o_timeout);
    end
endmodule

// File: rtl/strobe_monitor.sv
// strobe_monitor: grades strobe intervals early/good/late and locks after LOCK_COUNT good ones; STROBE_MONITOR_PERIOD_EN adds o_period
module strobe_monitor
  import strobe_pkg::*;
#(
  parameter int  DIV        = 10,
  parameter int  TOL        = 1,
  parameter int  LOCK_COUNT = 3,
  localparam int CW         = $clog2(DIV + TOL + 2)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_strobe,
  output logic          o_locked,
  output logic          o_early,
`ifdef STROBE_MONITOR_PERIOD_EN
  output logic          o_late,
  output logic [CW-1:0] o_period
`else
  output logic          o_late
`endif
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  if (!div_ok(DIV)) begin : g_div_err
    $error("strobe_monitor: DIV must be >= 2");
  end
  if (!tol_ok(DIV, TOL)) begin : g_tol_err
    $error("strobe_monitor: TOL must be in 0..DIV-1");
  end
  if (!lock_ok(LOCK_COUNT)) begin : g_lock_err
    $error("strobe_monitor: LOCK_COUNT must be >= 1");
  end
  strobe_mon_state_t state;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_inc;
  logic [CW-1:0] interval;
  logic timeout;
  logic timed_out;
  logic early;
  logic good;
  strobe_interval_timer #(.DIV(DIV), .TOL(TOL), .CW(CW)) u_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_strobe    (i_strobe),
    .o_interval  (interval),
    .o_timeout   (timeout),
    .o_timed_out (timed_out)
  );
  assign early    = is_early(int'(interval), DIV, TOL);
  assign good     = in_window(int'(interval), DIV, TOL);
  assign good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
  // lock FSM: timeout outranks a coincident strobe; a strobe after a timeout is only a new reference
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      o_locked <= 1'b0;
      o_early  <= 1'b0;
      o_late   <= 1'b0;
    end else begin
      o_early <= 1'b0;
      o_late  <= 1'b0;
      if (state == IDLE) begin
        if (i_strobe) begin
          state    <= ACQUIRE;
          good_cnt <= '0;
        end
      end else if (timeout) begin
        state    <= ACQUIRE;
        good_cnt <= '0;
        o_late   <= 1'b1;
        o_locked <= 1'b0;
      end else if (i_strobe && !timed_out) begin
        if (early) begin
          state    <= ACQUIRE;
          good_cnt <= '0;
          o_early  <= 1'b1;
          o_locked <= 1'b0;
        end else if (good) begin
          good_cnt <= good_inc;
          if (good_inc == GOOD_MAX) begin
            state    <= LOCKED;
            o_locked <= 1'b1;
          end
        end
      end
    end
`ifdef STROBE_MONITOR_PERIOD_EN
  logic graded;
  assign graded = (state != IDLE) && (timeout || (i_strobe && !timed_out));
  // last measured interval; a timeout records DIV+TOL+1
  always_ff @(posedge i_clk)
    o_period <= i_reset ? '0 : (graded ? interval : o_period);
`endif
`ifdef FORMAL
  logic past_valid;
  logic strobe_d;
  logic gap_late;
  logic locked_d;
  logic lost_once;
  // bookkeeping for the properties: late already reported in this gap, lock lost at least once
  always_ff @(posedge i_clk) begin
    past_valid <= !i_reset;
    strobe_d   <= i_strobe && !i_reset;
    gap_late   <= i_reset ? 1'b0 : (o_late ? !strobe_d : (strobe_d ? 1'b0 : gap_late));
    locked_d   <= o_locked;
    lost_once  <= i_reset ? 1'b0 : (lost_once || (locked_d && !o_locked));
  end
  a_no_early_late: assert property (@(posedge i_clk) disable iff (i_reset || !past_valid) !(o_early && o_late));
  a_late_once:     assert property (@(posedge i_clk) disable iff (i_reset || !past_valid) o_late |-> !gap_late);
  a_lock_good:     assert property (@(posedge i_clk) disable iff (i_reset || !past_valid) o_locked |-> good_cnt == GOOD_MAX);
  c_lock:          cover property (@(posedge i_clk) disable iff (i_reset) !locked_d && o_locked);
  c_relock:        cover property (@(posedge i_clk) disable iff (i_reset) lost_once && !locked_d && o_locked);
`endif
endmodule

// File: tb/tb_strobe_monitor.sv
// tb_strobe_monitor: vector table, corner sequences and random gaps checked against a timestamp reference model
module tb_strobe_monitor;
  localparam int DIV = 10;
  localparam int TOL = 1;
  localparam int LC  = 3;
  localparam int CW  = $clog2(DIV + TOL + 2);
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_strobe = 1'b0;
  logic o_locked;
  logic o_early;
  logic o_late;
`ifdef STROBE_MONITOR_PERIOD_EN
  logic [CW-1:0] o_period;
`endif
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic m_ref = 1'b0;
  logic m_late_done = 1'b0;
  logic m_lock = 1'b0;
  logic e_early = 1'b0;
  logic e_late = 1'b0;
  int m_last = 0;
  int m_good = 0;
  int m_period = 0;
  typedef struct {
    int   gap;
    int   n_early;
    int   n_late;
    logic locked;
  } vec_t;
  vec_t tbl [23];
  strobe_monitor #(.DIV(DIV), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_strobe (i_strobe),
    .o_locked (o_locked),
    .o_early  (o_early),
`ifdef STROBE_MONITOR_PERIOD_EN
    .o_late   (o_late),
    .o_period (o_period)
`else
    .o_late   (o_late)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask
  // reference: intervals are differences of absolute strobe timestamps
  task automatic model(input logic s, input logic r);
    int i;
    e_early = 1'b0;
    e_late  = 1'b0;
    if (r) begin
      m_ref = 1'b0;
      m_good = 0;
      m_lock = 1'b0;
      m_late_done = 1'b0;
      m_period = 0;
    end else if (!m_ref) begin
      if (s) begin
        m_ref = 1'b1;
        m_last = cyc;
      end
    end else begin
      i = cyc - m_last;
      if (!m_late_done && i == DIV + TOL + 1) begin
        e_late = 1'b1;
        m_good = 0;
        m_lock = 1'b0;
        m_period = i;
        m_late_done = !s;
        if (s) m_last = cyc;
      end else if (s) begin
        if (!m_late_done) begin
          m_period = i;
          if (i < DIV - TOL) begin
            e_early = 1'b1;
            m_good = 0;
            m_lock = 1'b0;
          end else begin
            m_good = (m_good < LC) ? m_good + 1 : LC;
            m_lock = m_lock || (m_good == LC);
          end
        end
        m_late_done = 1'b0;
        m_last = cyc;
      end
    end
    cyc++;
  endtask
  task automatic step(input logic s, input logic r);
    i_strobe = s;
    i_reset = r;
    model(s, r);
    @(posedge i_clk);
    #1;
    chk("o_early", int'(o_early), int'(e_early));
    chk("o_late", int'(o_late), int'(e_late));
    chk("o_locked", int'(o_locked), int'(m_lock));
`ifdef STROBE_MONITOR_PERIOD_EN
    chk("o_period", int'(o_period), m_period);
`endif
  endtask
  task automatic gap(input int g);
    for (int k = 1; k <= g; k++) step(k == g, 1'b0);
  endtask
  initial begin
    int ne;
    int nl;
    int g;
    tbl = '{'{3, 0, 0, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 1},
            '{7, 1, 0, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 1},
            '{9, 0, 0, 1}, '{11, 0, 0, 1}, '{8, 1, 0, 0}, '{9, 0, 0, 0},
            '{11, 0, 0, 0}, '{9, 0, 0, 1}, '{12, 0, 1, 0}, '{10, 0, 0, 0},
            '{20, 0, 1, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 0}, '{10, 0, 0, 1},
            '{1, 1, 0, 0}, '{9, 0, 0, 0}, '{40, 0, 1, 0}};
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("reset locked", int'(o_locked), 0);
    foreach (tbl[n]) begin
      ne = 0;
      nl = 0;
      for (int k = 1; k <= tbl[n].gap; k++) begin
        step(k == tbl[n].gap, 1'b0);
        ne += int'(o_early);
        nl += int'(o_late);
      end
      chk($sformatf("vec%0d early pulses", n), ne, tbl[n].n_early);
      chk($sformatf("vec%0d late pulses", n), nl, tbl[n].n_late);
      chk($sformatf("vec%0d locked", n), int'(o_locked), int'(tbl[n].locked));
    end
    repeat (3) gap(10);
    chk("relock before reset", int'(o_locked), 1);
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("reset+strobe locked", int'(o_locked), 0);
    chk("reset+strobe early", int'(o_early), 0);
    chk("reset+strobe late", int'(o_late), 0);
    repeat (3) gap(10);
    chk("post-reset 3 strobes", int'(o_locked), 0);
    gap(10);
    chk("post-reset 4 strobes", int'(o_locked), 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("held first early", int'(o_early), 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0);
      chk("held early", int'(o_early), 1);
      chk("held locked", int'(o_locked), 0);
    end
    step(1'b0, 1'b0);
    repeat (300) begin
      g = ($urandom_range(0, 9) < 7) ? int'($urandom_range(DIV - TOL - 1, DIV + TOL + 1)) : int'($urandom_range(1, 30));
      for (int k = 1; k <= g; k++) step(k == g, $urandom_range(0, 299) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
